// File: rtl/synth_param_bank.sv
// synth_param_bank: saturating bank of synth control registers stepped by inc/dec edges, selected by sel.
// Define AUTO_REPEAT_EN to add hold-to-repeat stepping (REPEAT_DELAY / REPEAT_RATE).
module synth_param_bank #(
  parameter int NUM_PARAMS = 6,
  parameter int WIDTH = 31,
  parameter int SEL_W = 3,
  parameter int STEP_SHIFT = 23,
  parameter logic [WIDTH-1:0] MAX_VAL = 31'h4000_0000,
  parameter logic [NUM_PARAMS*WIDTH-1:0] RESET_VALS = {6{31'h4000_0000}},
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE = 5_000_000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [SEL_W-1:0]            sel,
  input  logic                        inc,
  input  logic                        dec,
  output logic [NUM_PARAMS*WIDTH-1:0] params,
  output logic [3:0]                  disp_nibble,
  output logic                        sel_valid,
  output logic                        at_max,
  output logic                        at_min,
  output logic                        changed
);
  localparam logic [SEL_W:0] NP = NUM_PARAMS[SEL_W:0];
  localparam logic [WIDTH:0] STEP = {{WIDTH{1'b0}}, 1'b1} << STEP_SHIFT;
  if ((2 ** SEL_W) < NUM_PARAMS || STEP_SHIFT >= WIDTH || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
    $error("synth_param_bank: invalid parameter set");
  end
  logic [WIDTH-1:0] regs [NUM_PARAMS];
  logic [WIDTH-1:0] cur, up_val, down_val, nxt;
  logic [WIDTH:0] sum;
  logic inc_q, dec_q, rise_up, rise_dn, up, down, wr;
  assign rise_up = inc & ~inc_q & ~(dec & ~dec_q);
  assign rise_dn = dec & ~dec_q & ~(inc & ~inc_q);
  assign sel_valid = {1'b0, sel} < NP;
  always_comb begin
    cur = '0;
    for (int i = 0; i < NUM_PARAMS; i++) cur = (sel == SEL_W'(i)) ? regs[i] : cur;
  end
  assign sum = {1'b0, cur} + STEP;
  assign up_val = (sum > {1'b0, MAX_VAL}) ? MAX_VAL : sum[WIDTH-1:0];
  assign down_val = ({1'b0, cur} < STEP) ? '0 : cur - STEP[WIDTH-1:0];
  assign nxt = up ? up_val : down ? down_val : cur;
  assign wr = sel_valid & (up | down) & (nxt != cur);
  assign disp_nibble = sel_valid ? cur[WIDTH-1 -: 4] : 4'h0;
  assign at_max = sel_valid & (cur == MAX_VAL);
  assign at_min = sel_valid & (cur == '0);
  for (genvar i = 0; i < NUM_PARAMS; i++) begin : g_flat
    assign params[i*WIDTH +: WIDTH] = regs[i];
  end
`ifdef AUTO_REPEAT_EN
  localparam int CW = $clog2((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);
  typedef enum logic [1:0] {IDLE, WAIT, REPEAT} rep_t;
  rep_t state;
  logic dir, abort, tick;
  logic [CW-1:0] cnt;
  logic [SEL_W-1:0] sel_q;
  // a held key only repeats while it stays the sole key down on the same register
  assign abort = (dir ? ~inc : ~dec) | (inc & dec) | (sel != sel_q);
  assign tick = (state == WAIT) ? (~abort & (cnt == CW'(REPEAT_DELAY - 1))) :
                (state == REPEAT) ? (~abort & (cnt == CW'(REPEAT_RATE - 1))) : 1'b0;
  assign up = rise_up | (tick & dir);
  assign down = rise_dn | (tick & ~dir);
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      dir <= 1'b0;
      sel_q <= '0;
    end else begin
      sel_q <= sel;
      if (state == IDLE) begin
        cnt <= '0;
        if (rise_up | rise_dn) begin
          state <= WAIT;
          dir <= rise_up;
        end
      end else if (abort) begin
        state <= IDLE;
        cnt <= '0;
      end else if (tick) begin
        state <= REPEAT;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
`else
  assign up = rise_up;
  assign down = rise_dn;
`endif
  // edge registers reset high so a key held through reset must be re-pressed
  always_ff @(posedge clk) begin
    if (!reset) begin
      inc_q <= 1'b1;
      dec_q <= 1'b1;
      changed <= 1'b0;
      for (int i = 0; i < NUM_PARAMS; i++) regs[i] <= RESET_VALS[i*WIDTH +: WIDTH];
    end else begin
      inc_q <= inc;
      dec_q <= dec;
      changed <= wr;
      for (int i = 0; i < NUM_PARAMS; i++) if (wr && sel == SEL_W'(i)) regs[i] <= nxt;
    end
  end
endmodule

// File: tb/tb_synth_param_bank.sv
// tb_synth_param_bank: directed stimulus with a cycle-stamped scoreboard checked by a negedge monitor.
module tb_synth_param_bank;
  localparam int K_P = 0, K_CH = 1, K_MAX = 2, K_MIN = 3, K_SV = 4, K_NIB = 5;
  localparam logic [30:0] MX = 31'h4000_0000;
  localparam logic [30:0] ST = 31'h0080_0000;
  typedef struct {
    int cyc;
    int kind;
    int idx;
    logic [30:0] exp;
    string name;
  } exp_t;
  logic clk = 0, reset = 0, inc = 0, dec = 0;
  logic [2:0] sel = 0;
  logic [185:0] params;
  logic [3:0] disp_nibble;
  logic sel_valid, at_max, at_min, changed;
  int cyc = 0, n_checks = 0, n_pass = 0;
  exp_t q[$];
  exp_t m;
  logic [30:0] act;
  synth_param_bank #(.REPEAT_DELAY(8), .REPEAT_RATE(4)) dut (
    .clk(clk), .reset(reset), .sel(sel), .inc(inc), .dec(dec), .params(params),
    .disp_nibble(disp_nibble), .sel_valid(sel_valid), .at_max(at_max), .at_min(at_min),
    .changed(changed)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [30:0] actual(input int kind, input int idx);
    case (kind)
      K_P: return params[idx*31 +: 31];
      K_CH: return {30'd0, changed};
      K_MAX: return {30'd0, at_max};
      K_MIN: return {30'd0, at_min};
      K_SV: return {30'd0, sel_valid};
      default: return {27'd0, disp_nibble};
    endcase
  endfunction
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      m = q.pop_front();
      act = actual(m.kind, m.idx);
      n_checks++;
      if (m.cyc != cyc) $display("FAIL %s: stale expectation from cycle %0d at cycle %0d", m.name, m.cyc, cyc);
      else if (act !== m.exp) $display("FAIL %s: got 0x%08h expected 0x%08h", m.name, act, m.exp);
      else n_pass++;
    end
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input string nm, input int kind, input int idx, input logic [30:0] v);
    exp_t e;
    e.cyc = cyc;
    e.kind = kind;
    e.idx = idx;
    e.exp = v;
    e.name = nm;
    q.push_back(e);
  endtask
  task automatic press(input bit up_key);
    inc = up_key;
    dec = !up_key;
    tick();
    inc = 0;
    dec = 0;
    tick();
  endtask
  initial begin
    logic [30:0] v;
    tick();
    tick();
    reset = 1;
    tick();
    for (int i = 0; i < 6; i++) chk($sformatf("reset_p%0d", i), K_P, i, MX);
    chk("reset_changed", K_CH, 0, 0);
    chk("reset_at_max", K_MAX, 0, 1);
    chk("reset_at_min", K_MIN, 0, 0);
    chk("reset_sel_valid", K_SV, 0, 1);
    chk("reset_nibble", K_NIB, 0, 31'h8);
    sel = 1;
    dec = 1;
    tick();
    chk("dec1_p1", K_P, 1, 31'h3F80_0000);
    chk("dec1_changed", K_CH, 0, 1);
    chk("dec1_p0", K_P, 0, MX);
    chk("dec1_p2", K_P, 2, MX);
    chk("dec1_nibble", K_NIB, 0, 31'h7);
    dec = 0;
    tick();
    chk("dec1_changed_drop", K_CH, 0, 0);
    chk("dec1_p1_hold", K_P, 1, 31'h3F80_0000);
    sel = 3;
    for (int i = 0; i < 127; i++) press(0);
    chk("walk_p3", K_P, 3, ST);
    chk("walk_not_min", K_MIN, 0, 0);
    dec = 1;
    tick();
    chk("floor_p3", K_P, 3, 0);
    chk("floor_changed", K_CH, 0, 1);
    chk("floor_at_min", K_MIN, 0, 1);
    dec = 0;
    tick();
    dec = 1;
    tick();
    chk("floor2_p3", K_P, 3, 0);
    chk("floor2_changed", K_CH, 0, 0);
    dec = 0;
    tick();
    sel = 2;
    inc = 1;
    dec = 1;
    tick();
    chk("both_p2", K_P, 2, MX);
    chk("both_changed", K_CH, 0, 0);
    inc = 0;
    dec = 0;
    tick();
    chk("both_release_p2", K_P, 2, MX);
    sel = 0;
    inc = 1;
    tick();
    chk("sat_p0", K_P, 0, MX);
    chk("sat_changed", K_CH, 0, 0);
    chk("sat_at_max", K_MAX, 0, 1);
    inc = 0;
    tick();
    sel = 7;
    dec = 1;
    tick();
    chk("bad_sel_valid", K_SV, 0, 0);
    chk("bad_sel_changed", K_CH, 0, 0);
    chk("bad_sel_nibble", K_NIB, 0, 0);
    for (int i = 0; i < 6; i++) chk($sformatf("bad_sel_p%0d", i), K_P, i, (i == 1) ? 31'h3F80_0000 : (i == 3) ? 31'h0 : MX);
    dec = 0;
    tick();
    reset = 0;
    sel = 0;
    dec = 1;
    tick();
    tick();
    reset = 1;
    tick();
    chk("held_p0", K_P, 0, MX);
    chk("held_changed", K_CH, 0, 0);
    chk("held_p3_reset", K_P, 3, MX);
    tick();
    chk("held2_p0", K_P, 0, MX);
    dec = 0;
    tick();
    dec = 1;
    tick();
    chk("repress_p0", K_P, 0, 31'h3F80_0000);
    chk("repress_changed", K_CH, 0, 1);
    dec = 0;
    tick();
    sel = 4;
    dec = 1;
    tick();
    chk("hold_first_changed", K_CH, 0, 1);
    tick();
    chk("hold_second_changed", K_CH, 0, 0);
    for (int i = 2; i < 20; i++) tick();
`ifdef AUTO_REPEAT_EN
    v = MX - 4 * ST;
`else
    v = MX - ST;
`endif
    chk("hold_p4", K_P, 4, v);
    sel = 5;
    for (int i = 0; i < 12; i++) tick();
    chk("selchg_p5", K_P, 5, MX);
    chk("selchg_p4", K_P, 4, v);
    dec = 0;
    tick();
    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations never checked, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
